// File: rtl/core_run_ctrl.sv
`timescale 1ns/1ps
// core_run_ctrl: bring-up run controller for the RV64IF core.
// Holds the core in reset while IMem is preloaded, releases it for one
// settle cycle, runs it for RUN_CYCLES cycles, pulses the DMem finish
// strobe once and parks the core back in reset.
// Optional feature macro: RUN_CTRL_HALT_ON_ECALL_EN -- when defined, an
// ECALL/EBREAK fetched during RUN ends the run early and sets out_halted.
module core_run_ctrl #(
  parameter int RUN_CYCLES   = 1000,
  parameter int LOAD_TIMEOUT = 4096,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 in_Clk,
  input  logic                 Rst_N,
  input  logic                 in_done_load_inst,
  input  logic [31:0]          in_inst,
  output logic                 out_core_rst_n,
  output logic                 out_exe_finished,
  output logic [CNT_WIDTH-1:0] out_cycle_count,
  output logic                 out_done,
  output logic                 out_load_timeout,
  output logic                 out_halted,
  output logic [2:0]           out_state
);

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_FINISH  = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  // Timeout comparison value; unused when the timeout is disabled (0).
  localparam bit                   TIMEOUT_EN = (LOAD_TIMEOUT != 0);
  localparam logic [31:0]          LOAD_LAST  = (LOAD_TIMEOUT == 0) ? 32'd0 : 32'(LOAD_TIMEOUT - 1);
  // Count value seen during the last RUN cycle.
  localparam logic [CNT_WIDTH-1:0] RUN_LAST   = CNT_WIDTH'(RUN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  state_e                 state_q, state_d;
  logic [31:0]            load_tmr_q, load_tmr_d;
  logic [CNT_WIDTH-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic                   halt_req;

`ifdef RUN_CTRL_HALT_ON_ECALL_EN
  logic halted_q, halted_d;

  // An ECALL/EBREAK fetch requests an early end of the run.
  assign halt_req = (in_inst == INST_ECALL) || (in_inst == INST_EBREAK);

  // Halted flag is set by a halt request seen in RUN and stays set until reset.
  always_comb begin
    halted_d = halted_q;
    if ((state_q == ST_RUN) && halt_req) begin
      halted_d = 1'b1;
    end
  end

  // Halted flag register.
  always_ff @(posedge in_Clk) begin
    if (!Rst_N) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign out_halted = halted_q;
`else
  // Feature disabled: the fetched instruction plays no part in sequencing.
  logic unused_inst;
  assign unused_inst = ^{in_inst, INST_ECALL, INST_EBREAK};
  assign halt_req    = 1'b0;
  assign out_halted  = 1'b0;
`endif

  // Next-state, load timer and run counter logic.
  always_comb begin
    state_d     = state_q;
    load_tmr_d  = load_tmr_q;
    cycle_cnt_d = cycle_cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (load_tmr_q != 32'hFFFF_FFFF) begin
          load_tmr_d = load_tmr_q + 32'd1;
        end
        // A completed load wins over a coincident timeout.
        if (in_done_load_inst) begin
          state_d = ST_RELEASE;
        end else if (TIMEOUT_EN && (load_tmr_q == LOAD_LAST)) begin
          state_d = ST_ERROR;
        end
      end
      ST_RELEASE: begin
        // Single settle cycle for the core, not counted.
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cycle_cnt_q != CNT_MAX) begin
          cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        end
        if (halt_req || (cycle_cnt_q == RUN_LAST)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        // Unused encodings recover to LOAD.
        state_d = ST_LOAD;
      end
    endcase
  end

  // State, load timer and cycle counter registers.
  always_ff @(posedge in_Clk) begin
    if (!Rst_N) begin
      state_q     <= ST_LOAD;
      load_tmr_q  <= 32'd0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      load_tmr_q  <= load_tmr_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Moore outputs, decoded from the registered state only.
  assign out_core_rst_n   = (state_q == ST_RELEASE) || (state_q == ST_RUN) || (state_q == ST_FINISH);
  assign out_exe_finished = (state_q == ST_FINISH);
  assign out_done         = (state_q == ST_DONE);
  assign out_load_timeout = (state_q == ST_ERROR);
  assign out_cycle_count  = cycle_cnt_q;
  assign out_state        = state_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for core_run_ctrl: randomized scenarios compared
// against an event-level model of the run sequence.
module tb_core_run_ctrl;

  localparam int RC = 10;
  localparam int LT = 8;
  localparam int CW = 16;
`ifdef RUN_CTRL_HALT_ON_ECALL_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          done_load;
  logic [31:0]   inst;

  logic          a_core_rst_n, a_exe_finished, a_done, a_load_timeout, a_halted;
  logic [CW-1:0] a_cycle_count;
  logic [2:0]    a_state;
  logic          b_core_rst_n, b_exe_finished, b_done, b_load_timeout, b_halted;
  logic [CW-1:0] b_cycle_count;
  logic [2:0]    b_state;

  core_run_ctrl #(.RUN_CYCLES(RC), .LOAD_TIMEOUT(LT), .CNT_WIDTH(CW)) dut_a (
    .in_Clk(clk), .Rst_N(rst_n), .in_done_load_inst(done_load), .in_inst(inst),
    .out_core_rst_n(a_core_rst_n), .out_exe_finished(a_exe_finished),
    .out_cycle_count(a_cycle_count), .out_done(a_done),
    .out_load_timeout(a_load_timeout), .out_halted(a_halted), .out_state(a_state)
  );

  core_run_ctrl #(.RUN_CYCLES(RC), .LOAD_TIMEOUT(0), .CNT_WIDTH(CW)) dut_b (
    .in_Clk(clk), .Rst_N(rst_n), .in_done_load_inst(done_load), .in_inst(inst),
    .out_core_rst_n(b_core_rst_n), .out_exe_finished(b_exe_finished),
    .out_cycle_count(b_cycle_count), .out_done(b_done),
    .out_load_timeout(b_load_timeout), .out_halted(b_halted), .out_state(b_state)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected run profile; indices count edges from the first edge after reset release.
  typedef struct {
    int rise;      // first index with core_rst_n high (-1 none)
    int high;      // number of indices with core_rst_n high
    int fin_cnt;   // number of exe_finished cycles
    int fin_idx;   // index of the strobe (-1 none)
    int done_idx;  // first index with done (-1 none)
    int to_idx;    // first index with load_timeout (-1 none)
    int count;     // final cycle count
    bit halted;
    int state;     // final state code
  } exp_t;

  // Observations of the latest scenario.
  int            obs_rise, obs_high, obs_fin_cnt, obs_fin_idx, obs_done_idx, obs_to_idx;
  int            obs_b_high, obs_b_to;
  int            obs_mid_count;
  logic [CW-1:0] obs_count;
  logic          obs_halted, obs_done, obs_to, obs_core_rst_n, obs_fin;
  logic [2:0]    obs_state, obs_b_state;

  // Reference model: d = LOAD edges before the load is seen, ecall_at = RUN cycle with ECALL (0 none).
  function automatic exp_t model(input int d, input int ecall_at);
    exp_t e;
    int   eff;
    bit   hit;
    if (LT != 0 && d >= LT) begin
      e.rise = -1; e.high = 0; e.fin_cnt = 0; e.fin_idx = -1; e.done_idx = -1;
      e.to_idx = LT - 1; e.count = 0; e.halted = 1'b0; e.state = 5;
    end else begin
      hit = HALT_EN && (ecall_at >= 1) && (ecall_at <= RC);
      eff = hit ? ecall_at : RC;
      e.rise = d; e.high = eff + 2; e.fin_cnt = 1; e.fin_idx = d + 1 + eff;
      e.done_idx = d + 2 + eff; e.to_idx = -1; e.count = eff; e.halted = hit; e.state = 4;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] v;
    do v = $urandom; while (v == 32'h0000_0073 || v == 32'h0010_0073);
    return v;
  endfunction

  // Reset, release, then run ncyc observed edges. rst_at >= 0 drops Rst_N after that index.
  task automatic run_scenario(input int d, input int ecall_at, input int ncyc, input int rst_at);
    int m;
    rst_n = 1'b0; done_load = 1'b0; inst = rand_inst();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; done_load = (d == 0); inst = rand_inst();
    obs_rise = -1; obs_high = 0; obs_fin_cnt = 0; obs_fin_idx = -1; obs_done_idx = -1;
    obs_to_idx = -1; obs_b_high = 0; obs_b_to = 0; obs_mid_count = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (a_core_rst_n) begin
        if (obs_rise < 0) obs_rise = i;
        obs_high++;
      end
      if (a_exe_finished) begin
        obs_fin_cnt++;
        if (obs_fin_idx < 0) obs_fin_idx = i;
      end
      if (a_done && obs_done_idx < 0) obs_done_idx = i;
      if (a_load_timeout && obs_to_idx < 0) obs_to_idx = i;
      if (b_core_rst_n) obs_b_high++;
      if (b_load_timeout) obs_b_to++;
      if (i == rst_at) begin
        obs_mid_count = int'(a_cycle_count);
        rst_n = 1'b0;
      end
      m = i + 1;
      done_load = (m < d) ? 1'b0 : ((m == d) ? 1'b1 : 1'($urandom_range(0, 1)));
      if (ecall_at > 0 && i == d + ecall_at)
        inst = ($urandom_range(0, 1) == 1) ? 32'h0000_0073 : 32'h0010_0073;
      else
        inst = rand_inst();
    end
    obs_count = a_cycle_count; obs_halted = a_halted; obs_state = a_state;
    obs_done = a_done; obs_to = a_load_timeout; obs_core_rst_n = a_core_rst_n;
    obs_fin = a_exe_finished; obs_b_state = b_state;
    $display("scenario d=%0d ecall_at=%0d cycles=%0d: state=%0d count=%0d halted=%0b strobe_at=%0d done_at=%0d",
             d, ecall_at, ncyc, obs_state, obs_count, obs_halted, obs_fin_idx, obs_done_idx);
  endtask

  task automatic test_reset(input string tag);
    rst_n = 1'b0; done_load = 1'b1; inst = 32'h0000_0073;
    repeat (3) @(posedge clk);
    #1;
    $display("reset check %s", tag);
    total_cnt++; if (a_state !== 3'd0) $display("FAIL %s_state: got %0d expected 0", tag, a_state); else pass_cnt++;
    total_cnt++; if (a_core_rst_n !== 1'b0) $display("FAIL %s_core_rst_n: got %0b expected 0", tag, a_core_rst_n); else pass_cnt++;
    total_cnt++; if (a_exe_finished !== 1'b0) $display("FAIL %s_exe_finished: got %0b expected 0", tag, a_exe_finished); else pass_cnt++;
    total_cnt++; if (a_cycle_count !== '0) $display("FAIL %s_count: got %0d expected 0", tag, a_cycle_count); else pass_cnt++;
    total_cnt++; if (a_done !== 1'b0) $display("FAIL %s_done: got %0b expected 0", tag, a_done); else pass_cnt++;
    total_cnt++; if (a_load_timeout !== 1'b0) $display("FAIL %s_load_timeout: got %0b expected 0", tag, a_load_timeout); else pass_cnt++;
    total_cnt++; if (a_halted !== 1'b0) $display("FAIL %s_halted: got %0b expected 0", tag, a_halted); else pass_cnt++;
  endtask

  task automatic test_nominal();
    exp_t e;
    e = model(5, 0);
    run_scenario(5, 0, 5 + RC + 8, -1);
    total_cnt++; if (obs_rise !== e.rise) $display("FAIL nom_rise: got %0d expected %0d", obs_rise, e.rise); else pass_cnt++;
    total_cnt++; if (obs_high !== e.high) $display("FAIL nom_high_cycles: got %0d expected %0d", obs_high, e.high); else pass_cnt++;
    total_cnt++; if (obs_fin_cnt !== e.fin_cnt) $display("FAIL nom_strobe_cnt: got %0d expected %0d", obs_fin_cnt, e.fin_cnt); else pass_cnt++;
    total_cnt++; if (obs_fin_idx !== e.fin_idx) $display("FAIL nom_strobe_idx: got %0d expected %0d", obs_fin_idx, e.fin_idx); else pass_cnt++;
    total_cnt++; if (obs_done_idx !== e.done_idx) $display("FAIL nom_done_idx: got %0d expected %0d", obs_done_idx, e.done_idx); else pass_cnt++;
    total_cnt++; if (int'(obs_count) !== e.count) $display("FAIL nom_count: got %0d expected %0d", obs_count, e.count); else pass_cnt++;
    total_cnt++; if (int'(obs_state) !== e.state) $display("FAIL nom_state: got %0d expected %0d", obs_state, e.state); else pass_cnt++;
    total_cnt++; if (obs_core_rst_n !== 1'b0) $display("FAIL nom_core_parked: got %0b expected 0", obs_core_rst_n); else pass_cnt++;
    total_cnt++; if (obs_halted !== 1'b0) $display("FAIL nom_halted: got %0b expected 0", obs_halted); else pass_cnt++;
    total_cnt++; if (obs_b_high !== e.high) $display("FAIL nom_b_high_cycles: got %0d expected %0d", obs_b_high, e.high); else pass_cnt++;
  endtask

  task automatic test_load_timeout();
    exp_t e;
    e = model(1000, 0);
    run_scenario(1000, 0, 40, -1);
    total_cnt++; if (obs_to_idx !== e.to_idx) $display("FAIL to_idx: got %0d expected %0d", obs_to_idx, e.to_idx); else pass_cnt++;
    total_cnt++; if (int'(obs_state) !== e.state) $display("FAIL to_state: got %0d expected %0d", obs_state, e.state); else pass_cnt++;
    total_cnt++; if (obs_to !== 1'b1) $display("FAIL to_flag: got %0b expected 1", obs_to); else pass_cnt++;
    total_cnt++; if (obs_rise !== e.rise) $display("FAIL to_core_rise: got %0d expected %0d", obs_rise, e.rise); else pass_cnt++;
    total_cnt++; if (obs_fin_cnt !== e.fin_cnt) $display("FAIL to_strobe_cnt: got %0d expected %0d", obs_fin_cnt, e.fin_cnt); else pass_cnt++;
    total_cnt++; if (obs_done !== 1'b0) $display("FAIL to_done: got %0b expected 0", obs_done); else pass_cnt++;
    total_cnt++; if (obs_b_state !== 3'd0) $display("FAIL to_b_waits_state: got %0d expected 0", obs_b_state); else pass_cnt++;
    total_cnt++; if (obs_b_to !== 0) $display("FAIL to_b_timeout_cycles: got %0d expected 0", obs_b_to); else pass_cnt++;
    total_cnt++; if (obs_b_high !== 0) $display("FAIL to_b_core_high: got %0d expected 0", obs_b_high); else pass_cnt++;
  endtask

  task automatic test_collision();
    exp_t e;
    e = model(LT - 1, 0);
    run_scenario(LT - 1, 0, LT + RC + 8, -1);
    total_cnt++; if (obs_to_idx !== e.to_idx) $display("FAIL coll_timeout_idx: got %0d expected %0d", obs_to_idx, e.to_idx); else pass_cnt++;
    total_cnt++; if (obs_rise !== e.rise) $display("FAIL coll_rise: got %0d expected %0d", obs_rise, e.rise); else pass_cnt++;
    total_cnt++; if (int'(obs_state) !== e.state) $display("FAIL coll_state: got %0d expected %0d", obs_state, e.state); else pass_cnt++;
    total_cnt++; if (int'(obs_count) !== e.count) $display("FAIL coll_count: got %0d expected %0d", obs_count, e.count); else pass_cnt++;
  endtask

  task automatic test_mid_run_reset();
    exp_t e;
    int   d;
    d = int'($urandom_range(0, 4));
    // Cycle count reads 4 during the 5th RUN cycle.
    run_scenario(d, 0, d + 7, d + 5);
    total_cnt++; if (obs_mid_count !== 4) $display("FAIL mid_count_before: got %0d expected 4", obs_mid_count); else pass_cnt++;
    total_cnt++; if (obs_state !== 3'd0) $display("FAIL mid_state: got %0d expected 0", obs_state); else pass_cnt++;
    total_cnt++; if (obs_core_rst_n !== 1'b0) $display("FAIL mid_core_rst_n: got %0b expected 0", obs_core_rst_n); else pass_cnt++;
    total_cnt++; if (obs_count !== '0) $display("FAIL mid_count_after: got %0d expected 0", obs_count); else pass_cnt++;
    total_cnt++; if (obs_fin_cnt !== 0) $display("FAIL mid_no_strobe: got %0d expected 0", obs_fin_cnt); else pass_cnt++;
    total_cnt++; if (obs_done !== 1'b0 || obs_halted !== 1'b0 || obs_to !== 1'b0 || obs_fin !== 1'b0)
      $display("FAIL mid_flags: got done=%0b halted=%0b to=%0b fin=%0b expected all 0", obs_done, obs_halted, obs_to, obs_fin);
    else pass_cnt++;
    d = int'($urandom_range(0, 4));
    e = model(d, 0);
    run_scenario(d, 0, d + RC + 8, -1);
    total_cnt++; if (int'(obs_count) !== e.count) $display("FAIL mid_rerun_count: got %0d expected %0d", obs_count, e.count); else pass_cnt++;
    total_cnt++; if (int'(obs_state) !== e.state) $display("FAIL mid_rerun_state: got %0d expected %0d", obs_state, e.state); else pass_cnt++;
  endtask

  task automatic test_halt();
    exp_t e;
    int   d;
    int   pos [2];
    pos[0] = 3;
    pos[1] = RC;
    for (int k = 0; k < 2; k++) begin
      d = int'($urandom_range(0, 5));
      e = model(d, pos[k]);
      run_scenario(d, pos[k], d + RC + 8, -1);
      total_cnt++; if (int'(obs_count) !== e.count) $display("FAIL halt%0d_count: got %0d expected %0d", pos[k], obs_count, e.count); else pass_cnt++;
      total_cnt++; if (obs_halted !== e.halted) $display("FAIL halt%0d_halted: got %0b expected %0b", pos[k], obs_halted, e.halted); else pass_cnt++;
      total_cnt++; if (obs_fin_idx !== e.fin_idx) $display("FAIL halt%0d_strobe_idx: got %0d expected %0d", pos[k], obs_fin_idx, e.fin_idx); else pass_cnt++;
      total_cnt++; if (obs_done_idx !== e.done_idx) $display("FAIL halt%0d_done_idx: got %0d expected %0d", pos[k], obs_done_idx, e.done_idx); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   d, ec;
    for (int k = 0; k < 8; k++) begin
      d  = int'($urandom_range(0, LT + 1));
      ec = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, RC + 2));
      e  = model(d, ec);
      run_scenario(d, ec, d + RC + 8, -1);
      total_cnt++; if (int'(obs_state) !== e.state) $display("FAIL rnd%0d_state: got %0d expected %0d", k, obs_state, e.state); else pass_cnt++;
      total_cnt++; if (int'(obs_count) !== e.count) $display("FAIL rnd%0d_count: got %0d expected %0d", k, obs_count, e.count); else pass_cnt++;
      total_cnt++; if (obs_halted !== e.halted) $display("FAIL rnd%0d_halted: got %0b expected %0b", k, obs_halted, e.halted); else pass_cnt++;
      total_cnt++; if (obs_fin_idx !== e.fin_idx || obs_fin_cnt !== e.fin_cnt)
        $display("FAIL rnd%0d_strobe: got idx=%0d cnt=%0d expected idx=%0d cnt=%0d", k, obs_fin_idx, obs_fin_cnt, e.fin_idx, e.fin_cnt);
      else pass_cnt++;
      total_cnt++; if (obs_to_idx !== e.to_idx) $display("FAIL rnd%0d_timeout_idx: got %0d expected %0d", k, obs_to_idx, e.to_idx); else pass_cnt++;
      total_cnt++; if (obs_high !== e.high) $display("FAIL rnd%0d_high_cycles: got %0d expected %0d", k, obs_high, e.high); else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    done_load = 1'b0;
    inst = 32'd0;
    test_reset("reset_initial");
    test_nominal();
    test_load_timeout();
    test_reset("reset_after_error");
    test_collision();
    test_mid_run_reset();
    test_halt();
    test_reset("reset_after_done");
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
